multicycle_ctrl: RTL and testbench

//  Multi-cycle control unit for the ARM processor. Sequences one shared ALU/memory datapath through the fetch, decode, execute, memory and writeback steps.

---
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle ARM control unit: sequences the shared ALU/memory datapath
// through fetch, decode, execute, memory and writeback, owns the NZCV flag
// register and gates every architectural write with the condition check.
//
// Ports
//   CLK, RESETn         clock, asynchronous active-low reset
//   Instr[31:0]         IR contents (cond, op, funct, Rd fields used)
//   FlagW[1:0]          [1] update N,Z  [0] update C,V   (from Decoder)
//   NoWrite             suppress register writeback (CMP/CMN)
//   ALUFlags[3:0]       {N,Z,C,V} from the ALU, sampled on EXEC exit
//   MemReady            memory completes the current access this cycle
//   IRWrite, PCWrite, RegWrite, MemWrite, MemReq   write enables / handshake
//   AdrSrc, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], ResultSrc[1:0]  datapath muxes
//   Flags[3:0]          registered NZCV
//   Undef               one-cycle pulse when op=11 is decoded
module multicycle_ctrl #(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [31:0] Instr,
  input  logic [1:0]  FlagW,
  input  logic        NoWrite,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ResultSrc,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemReq,
  output logic [3:0]  Flags,
  output logic        Undef
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       rd_is_pc;
  logic [1:0] op;
  logic       unused_instr_bits;

  assign op       = Instr[27:26];
  assign rd_is_pc = (Instr[15:12] == PC_REG);
  assign Flags    = flags_q;

  // Instruction fields this unit does not look at.
  assign unused_instr_bits = ^{Instr[24], Instr[22:21], Instr[19:16], Instr[11:0]};

  // Condition evaluation against the registered flags.
  always_comb begin : cond_eval
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b1;
    case (Instr[31:28])
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= FETCH;
    else         state <= state_next;
  end

  // Flag register: loads on EXEC exit when the instruction executes.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      flags_q <= 4'b0000;
    end else if (((state == EXECR) || (state == EXECI)) && cond_ex) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (MemReady) state_next = DECODE;
      DECODE: begin
        case (op)
          2'b00:   state_next = Instr[25] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = Instr[20] ? MEMRD : MEMWR;
      MEMRD:  if (MemReady) state_next = MEMWB;
      MEMWB:  state_next = FETCH;
      // A failed condition skips the store without touching memory.
      MEMWR:  if (!cond_ex || MemReady) state_next = FETCH;
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Moore outputs per state, plus CondEx/MemReady gating of the strobes.
  always_comb begin
    logic reg_wr;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemReq    = 1'b0;
    Undef     = 1'b0;
    reg_wr    = 1'b0;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Undef   = (op == 2'b11);
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ALUOp   = Instr[23] ? 2'b00 : 2'b01;
      end
      MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_is_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemReq   = cond_ex;
        MemWrite = cond_ex;
      end
      EXECR: begin
        ALUOp = 2'b11;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      ALUWB: begin
        reg_wr   = cond_ex & ~NoWrite;
        RegWrite = reg_wr;
        PCWrite  = reg_wr & rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    // No write or access may escape while reset is held.
    if (!RESETn) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemReq   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a behavioural instruction-level
// model expands each instruction into per-cycle expected outputs, which a
// monitor compares against the DUT on every falling clock edge.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [31:0] Instr;
  logic [1:0]  FlagW;
  logic        NoWrite;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, MemReq, Undef;
  logic [1:0]  ALUSrcB, ALUOp, ResultSrc;
  logic [3:0]  Flags;

  multicycle_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .Instr(Instr), .FlagW(FlagW), .NoWrite(NoWrite),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemReq(MemReq),
    .Flags(Flags), .Undef(Undef)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] res;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic       memreq;
    logic       undef;
  } out_t;

  typedef struct {
    out_t       o;
    logic [3:0] fl;
    string      tag;
  } exp_t;

  typedef struct {
    logic        mr;
    logic [31:0] ins;
    logic [3:0]  af;
    exp_t        e;
  } cyc_t;

  exp_t       sb_q[$];
  cyc_t       cyc_q[$];
  logic [3:0] mflags;
  logic [1:0] cur_fw;
  logic       cur_nw;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc_no  = 0;

  // ARM condition: pairs of codes share a base test, odd codes invert it.
  function automatic logic model_condex(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b1;
    return base ^ cond[0];
  endfunction

  function automatic out_t mk(input logic irw, input logic adr, input logic srca,
                              input logic [1:0] srcb, input logic [1:0] aluop,
                              input logic [1:0] res, input logic pcw, input logic regw,
                              input logic memw, input logic memreq, input logic undef);
    out_t o;
    o = '{irw, adr, srca, srcb, aluop, res, pcw, regw, memw, memreq, undef};
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic mr, input logic [31:0] ins, input logic [3:0] af,
                     input out_t o, input string tag);
    cyc_t c;
    c.mr = mr; c.ins = ins; c.af = af;
    c.e.o = o; c.e.fl = mflags; c.e.tag = tag;
    cyc_q.push_back(c);
  endtask

  // Expand one instruction into its cycle-by-cycle drive and expectation.
  task automatic gen_instr(input logic [31:0] ins, input logic [1:0] fw, input logic nw,
                           input logic [3:0] af, input int fwait, input int dwait);
    logic       ce, rdpc;
    logic [1:0] op;
    op   = ins[27:26];
    rdpc = (ins[15:12] == 4'd15);
    ce   = model_condex(ins[31:28], mflags);
    cyc_q.delete();
    cur_fw = fw;
    cur_nw = nw;
    for (int i = 0; i < fwait; i++)
      add(1'b0, $urandom(), 4'($urandom()), mk(0, 0, 1, 2'd2, 2'd0, 2'd2, 0, 0, 0, 1, 0), "FETCH_WAIT");
    add(1'b1, $urandom(), 4'($urandom()), mk(1, 0, 1, 2'd2, 2'd0, 2'd2, 1, 0, 0, 1, 0), "FETCH");
    add(rb(), ins, 4'($urandom()), mk(0, 0, 1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, op == 2'b11), "DECODE");
    case (op)
      2'b00: begin
        add(rb(), ins, af, mk(0, 0, 0, ins[25] ? 2'd1 : 2'd0, 2'd3, 2'd0, 0, 0, 0, 0, 0), "EXEC");
        if (ce) begin
          if (fw[1]) mflags[3:2] = af[3:2];
          if (fw[0]) mflags[1:0] = af[1:0];
        end
        add(rb(), ins, 4'($urandom()),
            mk(0, 0, 0, 2'd0, 2'd0, 2'd0, ce & ~nw & rdpc, ce & ~nw, 0, 0, 0), "ALUWB");
      end
      2'b01: begin
        add(rb(), ins, 4'($urandom()), mk(0, 0, 0, 2'd1, ins[23] ? 2'd0 : 2'd1, 2'd0, 0, 0, 0, 0, 0), "MEMADR");
        if (ins[20]) begin
          for (int i = 0; i < dwait; i++)
            add(1'b0, ins, 4'($urandom()), mk(0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0), "MEMRD_WAIT");
          add(1'b1, ins, 4'($urandom()), mk(0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0), "MEMRD");
          add(rb(), ins, 4'($urandom()), mk(0, 0, 0, 2'd0, 2'd0, 2'd1, ce & rdpc, ce, 0, 0, 0), "MEMWB");
        end else if (ce) begin
          for (int i = 0; i < dwait; i++)
            add(1'b0, ins, 4'($urandom()), mk(0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1, 0), "MEMWR_WAIT");
          add(1'b1, ins, 4'($urandom()), mk(0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 1, 0), "MEMWR");
        end else begin
          add(rb(), ins, 4'($urandom()), mk(0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0), "MEMWR_SKIP");
        end
      end
      2'b10: add(rb(), ins, 4'($urandom()), mk(0, 0, 0, 2'd1, 2'd0, 2'd2, ce, 0, 0, 0, 0), "BRANCH");
      default: ;
    endcase
  endtask

  // Queue the first n expectations, then drive those cycles.
  task automatic run_cycles(input int n);
    int m;
    m = (n < cyc_q.size()) ? n : cyc_q.size();
    for (int i = 0; i < m; i++) sb_q.push_back(cyc_q[i].e);
    for (int i = 0; i < m; i++) begin
      MemReady = cyc_q[i].mr;
      Instr    = cyc_q[i].ins;
      ALUFlags = cyc_q[i].af;
      FlagW    = cur_fw;
      NoWrite  = cur_nw;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [1:0] fw, input logic nw,
                           input logic [3:0] af, input int fwait, input int dwait);
    gen_instr(ins, fw, nw, af, fwait, dwait);
    run_cycles(cyc_q.size());
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_strobes"}, 32'({IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Undef}), 32'd0);
    chk({tag, "_flags"}, 32'(Flags), 32'd0);
  endtask

  task automatic random_instr();
    logic [31:0] ins;
    logic [1:0]  fw;
    logic [3:0]  af, upd;
    int          kind;
    kind = $urandom_range(0, 9);
    ins  = $urandom();
    ins[31:28] = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
    if (kind <= 2)      ins[27:26] = 2'b00;
    else if (kind <= 4) begin ins[27:26] = 2'b01; ins[20] = 1'b1; end
    else if (kind <= 6) begin ins[27:26] = 2'b01; ins[20] = 1'b0; end
    else if (kind <= 8) ins[27:26] = 2'b10;
    else                ins[27:26] = 2'b11;
    fw = 2'($urandom_range(0, 3));
    af = 4'($urandom_range(0, 15));
    // Stay clear of an instruction whose own flag update would flip its condition.
    if (ins[27:26] == 2'b00 && fw != 2'b00) begin
      upd = mflags;
      if (fw[1]) upd[3:2] = af[3:2];
      if (fw[0]) upd[1:0] = af[1:0];
      if (model_condex(ins[31:28], mflags) != model_condex(ins[31:28], upd)) af = mflags;
    end
    run_instr(ins, fw, rb(), af, $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  // Monitor: one expected vector per cycle while the scoreboard is non-empty.
  initial begin
    exp_t e;
    out_t act;
    forever begin
      @(negedge CLK);
      cyc_no++;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               PCWrite, RegWrite, MemWrite, MemReq, Undef};
        n_tests++;
        if (act !== e.o || Flags !== e.fl) begin
          n_fail++;
          $display("FAIL %s cycle %0d: outputs %b flags %b, required outputs %b flags %b",
                   e.tag, cyc_no, act, Flags, e.o, e.fl);
        end
      end
    end
  end

  initial begin
    RESETn = 1'b1; Instr = '0; FlagW = '0; NoWrite = 1'b0; ALUFlags = '0; MemReady = 1'b0;
    mflags = 4'b0000; cur_fw = '0; cur_nw = 1'b0;
    #1 RESETn = 1'b0;
    #2 check_reset("power_on_reset");
    @(posedge CLK);
    @(negedge CLK) RESETn = 1'b1;
    @(posedge CLK);
    #1;

    // ADD R1,R2,R3 (AL)
    run_instr({4'hE, 2'b00, 6'b001000, 4'd2, 4'd1, 12'h003}, 2'b00, 1'b0, 4'b1111, 0, 0);
    // SUBS R0,R0,#1 -> Z set
    run_instr({4'hE, 2'b00, 6'b100101, 4'd0, 4'd0, 12'h001}, 2'b11, 1'b0, 4'b0100, 1, 0);
    // BEQ taken, BNE not taken
    run_instr({4'h0, 2'b10, 26'h0000010}, 2'b00, 1'b0, 4'b0000, 0, 0);
    run_instr({4'h1, 2'b10, 26'h0000020}, 2'b00, 1'b0, 4'b0000, 0, 0);
    // LDRNE R4 while Z=1 -> suppressed
    run_instr({4'h1, 2'b01, 6'b011001, 4'd1, 4'd4, 12'h004}, 2'b00, 1'b0, 4'b0000, 0, 0);
    // LDR R4,[R1,#4] with three wait cycles in MEMRD
    run_instr({4'hE, 2'b01, 6'b011001, 4'd1, 4'd4, 12'h004}, 2'b00, 1'b0, 4'b0000, 0, 3);
    // CMP R1,R1 -> flags 0110, no writeback
    run_instr({4'hE, 2'b00, 6'b010101, 4'd1, 4'd0, 12'h001}, 2'b11, 1'b1, 4'b0110, 0, 0);
    // LDR PC,[R1]
    run_instr({4'hE, 2'b01, 6'b011001, 4'd1, 4'd15, 12'h000}, 2'b00, 1'b0, 4'b0000, 0, 1);
    // STR with fetch and data waits
    run_instr({4'hE, 2'b01, 6'b011000, 4'd1, 4'd3, 12'h008}, 2'b00, 1'b0, 4'b0000, 1, 2);
    // op=11 undefined
    run_instr({4'hE, 2'b11, 26'h0123456}, 2'b00, 1'b0, 4'b0000, 0, 0);

    // Reset in the middle of a stalled store.
    gen_instr({4'hE, 2'b01, 6'b011000, 4'd1, 4'd3, 12'h000}, 2'b00, 1'b0, 4'b0000, 0, 3);
    run_cycles(4);
    MemReady = 1'b0;
    chk("memwr_before_reset", 32'(MemWrite), 32'd1);
    #2 RESETn = 1'b0;
    #1 check_reset("reset_in_memwr");
    mflags = 4'b0000;
    @(posedge CLK);
    @(negedge CLK) RESETn = 1'b1;
    @(posedge CLK);
    #1;

    for (int k = 0; k < 200; k++) random_instr();

    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
